// File: rtl/ucode_sequencer.sv
// ucode_sequencer: parametrised microcode step/flag sequencer with single-step, halt and retired count.
// Define UCODE_T_OPTIM_EN to let cw_in[TRST_BIT] end an instruction early.
module ucode_sequencer #(
  parameter int OPCODE_W     = 4,
  parameter int STEP_W       = 3,
  parameter int MAX_STEPS    = 5,
  parameter int NFLAGS       = 2,
  parameter int CW_W         = 16,
  parameter int HLT_BIT      = 0,
  parameter int FLAGS_WR_BIT = 8,
  parameter int TRST_BIT     = 15,
  parameter int ICNT_W       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              run,
  input  logic                              step_req,
  input  logic [OPCODE_W-1:0]               opcode_in,
  input  logic [NFLAGS-1:0]                 flags_in,
  input  logic [CW_W-1:0]                   cw_in,
  output logic [NFLAGS+OPCODE_W+STEP_W-1:0] ucode_addr,
  output logic [CW_W-1:0]                   cw_out,
  output logic [STEP_W-1:0]                 step,
  output logic [NFLAGS-1:0]                 flags,
  output logic                              halted,
  output logic [ICNT_W-1:0]                 instr_count
);
  logic step_req_q;
  logic active;
  logic eoi;
  assign active     = !rst && !halted && (run || (step_req && !step_req_q));
  assign cw_out     = active ? cw_in : '0;
  assign ucode_addr = {flags, opcode_in, step};
`ifdef UCODE_T_OPTIM_EN
  assign eoi = (step == STEP_W'(MAX_STEPS - 1)) || cw_in[TRST_BIT];
`else
  logic unused_trst;
  assign unused_trst = cw_in[TRST_BIT];
  assign eoi = step == STEP_W'(MAX_STEPS - 1);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      step        <= '0;
      flags       <= '0;
      halted      <= 1'b0;
      instr_count <= '0;
      step_req_q  <= 1'b0;
    end else begin
      step_req_q <= step_req;
      if (active) begin
        if (cw_in[FLAGS_WR_BIT]) flags <= flags_in;
        if (cw_in[HLT_BIT]) halted <= 1'b1;
        else if (eoi) begin
          step        <= '0;
          instr_count <= instr_count + 1'b1;
        end else step <= step + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: directed scoreboard bench for ucode_sequencer with a behavioural ROM.
module tb_ucode_sequencer;
`ifdef UCODE_T_OPTIM_EN
  localparam int P = 3;
`else
  localparam int P = 5;
`endif
  logic clk = 0, rst, run, step_req;
  logic [3:0] opcode_in = 4'h5;
  logic [1:0] flags_in, flags;
  logic [15:0] cw_in, cw_out;
  logic [8:0] ucode_addr;
  logic [2:0] step;
  logic halted;
  logic [3:0] instr_count;
  int mode;
  int checks = 0, failures = 0;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t sb[$];

  ucode_sequencer #(.ICNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .step_req(step_req), .opcode_in(opcode_in),
    .flags_in(flags_in), .cw_in(cw_in), .ucode_addr(ucode_addr), .cw_out(cw_out),
    .step(step), .flags(flags), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cw_of(input int m, input logic [2:0] s);
    logic [15:0] w;
    w = 16'h7000 | {12'b0, s, 1'b0};
    if (m == 1 && s == 3'd2) w[15] = 1'b1;
    if (m == 2 && s == 3'd3) w[8] = 1'b1;
    if (m == 3 && s == 3'd4) w[0] = 1'b1;
    return w;
  endfunction

  always_comb cw_in = cw_of(mode, ucode_addr[2:0]);

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] o);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%0h", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.v) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.v);
      end
    end
  endtask

  task automatic expect_now(input string t, input logic [31:0] v, input logic [31:0] o);
    push(t, v);
    chk(o);
  endtask

  task automatic reset_dut;
    rst = 1;
    cyc;
    expect_now("rst_cw", 0, cw_out);
    rst = 0;
  endtask

  initial begin
    rst = 1; run = 1; step_req = 0; flags_in = 0; mode = 0;
    cyc; cyc;
    expect_now("rst_cw0", 0, cw_out);
    expect_now("rst_step", 0, step);
    expect_now("rst_flags", 0, flags);
    expect_now("rst_halted", 0, halted);
    expect_now("rst_icnt", 0, instr_count);
    expect_now("rst_addr", {2'b00, 4'h5, 3'd0}, ucode_addr);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      push("fr_step", i % 5);
      push("fr_cw", cw_of(0, 3'(i % 5)));
    end
    for (int i = 0; i < 10; i++) begin
      #1; chk(step); chk(cw_out); cyc;
    end
    expect_now("fr_icnt", 2, instr_count);

    mode = 1;
    reset_dut;
    for (int i = 0; i < 15; i++) begin
      push("et_step", i % P);
      push("et_cw", cw_of(1, 3'(i % P)));
    end
    for (int i = 0; i < 15; i++) begin
      #1; chk(step); chk(cw_out); cyc;
    end
    expect_now("et_icnt", 15 / P, instr_count);

    mode = 0; run = 0;
    reset_dut;
    step_req = 1;
    for (int i = 0; i < 10; i++) begin
      #1; expect_now("ss_hold_cw", i == 0 ? cw_of(0, 0) : 16'h0, cw_out); cyc;
    end
    expect_now("ss_step1", 1, step);
    step_req = 0;
    for (int i = 0; i < 3; i++) begin
      #1; expect_now("ss_low_cw", 0, cw_out); cyc;
    end
    step_req = 1;
    #1; expect_now("ss_edge_cw", cw_of(0, 1), cw_out);
    cyc; cyc; cyc;
    expect_now("ss_step2", 2, step);
    step_req = 0; run = 1;
    cyc;
    expect_now("mc_run_step", 3, step);
    run = 0; step_req = 1;
    #1; expect_now("mc_edge_cw", cw_of(0, 3), cw_out);
    cyc; cyc; cyc;
    expect_now("mc_step", 4, step);

    run = 1; step_req = 0; mode = 2; flags_in = 2'b10;
    reset_dut;
    for (int i = 0; i < 4; i++) begin
      #1; expect_now("fl_pre", 0, flags); cyc;
    end
    expect_now("fl_latched", 2'b10, flags);
    expect_now("fl_addr", {2'b10, 4'h5, 3'd4}, ucode_addr);
    flags_in = 2'b01;
    cyc; cyc; cyc;
    expect_now("fl_hold", 2'b10, flags);
    expect_now("fl_hold_step", 2, step);

    mode = 3;
    reset_dut;
    repeat (4) cyc;
    expect_now("hl_cw", cw_of(3, 4), cw_out);
    cyc;
    expect_now("hl_halted", 1, halted);
    expect_now("hl_step", 4, step);
    expect_now("hl_cw0", 0, cw_out);
    expect_now("hl_icnt", 0, instr_count);
    cyc; cyc; cyc;
    expect_now("hl_sticky", 1, halted);
    expect_now("hl_step_hold", 4, step);
    reset_dut;
    #1;
    expect_now("hl_rst_halted", 0, halted);
    expect_now("hl_rst_step", 0, step);
    expect_now("hl_rst_flags", 0, flags);
    cyc;
    expect_now("hl_resume", 1, step);

    mode = 0;
    reset_dut;
    repeat (75) cyc;
    expect_now("wr_icnt15", 15, instr_count);
    repeat (5) cyc;
    expect_now("wr_icnt0", 0, instr_count);
    expect_now("wr_step0", 0, step);
    cyc; cyc;
    expect_now("wr_step2", 2, step);
    rst = 1;
    #1; expect_now("mr_cw", 0, cw_out);
    cyc;
    expect_now("mr_step", 0, step);
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
